// File: rtl/memory_write_loader_if.sv
// Loader-side bus: burst request, data stream and array write strobe.
// Optional checksum signal is present only when LOADER_CHECKSUM_EN is defined.
interface memory_write_loader_if #(
    parameter int unsigned word_size = 9
);
    logic                 start;
    logic [word_size-1:0] base_addr;
    logic [word_size:0]   count;
    logic                 abort;
    logic                 in_valid;
    logic [word_size-1:0] in_data;
    logic                 in_ready;
    logic                 we;
    logic [word_size-1:0] wa;
    logic [word_size-1:0] wd;
    logic                 busy;
    logic                 done;
`ifdef LOADER_CHECKSUM_EN
    logic [word_size-1:0] checksum;
`endif

    modport master (
        output start, base_addr, count, abort, in_valid, in_data,
        input  in_ready, we, wa, wd, busy, done
`ifdef LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  start, base_addr, count, abort, in_valid, in_data,
        output in_ready, we, wa, wd, busy, done
`ifdef LOADER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/memory_write_loader.sv
// Burst write loader: turns a valid/ready word stream into registered array writes
// with auto-incrementing, wrapping address. LOADER_CHECKSUM_EN adds a burst checksum.
module memory_write_loader #(
    parameter int unsigned word_size   = 9,
    parameter int unsigned memory_size = 512
) (
    input logic             clk,
    input logic             rst,
    memory_write_loader_if.slave bus
);
    localparam int unsigned cnt_w = word_size + 1;
    localparam logic [cnt_w-1:0]     max_count = cnt_w'(memory_size);
    localparam logic [word_size-1:0] last_addr = word_size'(memory_size - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t               state, state_nx;
    logic [word_size-1:0] addr, addr_nx;
    logic [cnt_w-1:0]     remaining, remaining_nx;
    logic                 we_q, we_nx;
    logic [word_size-1:0] wa_q, wa_nx;
    logic [word_size-1:0] wd_q, wd_nx;
    logic                 busy_q, busy_nx;
    logic                 done_q, done_nx;
    logic                 ready_c;
`ifdef LOADER_CHECKSUM_EN
    logic [word_size-1:0] sum_q, sum_nx;
`endif

    // Ready is combinational so abort blocks acceptance in the same cycle.
    assign ready_c      = (state == LOAD) && !bus.abort;
    assign bus.in_ready = ready_c;
    assign bus.we       = we_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign bus.checksum = sum_q;
`endif

    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        remaining_nx = remaining;
        we_nx        = 1'b0;
        wa_nx        = wa_q;
        wd_nx        = wd_q;
`ifdef LOADER_CHECKSUM_EN
        sum_nx       = sum_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    addr_nx      = bus.base_addr;
                    remaining_nx = (bus.count > max_count) ? max_count : bus.count;
                    state_nx     = (bus.count == '0) ? DONE : LOAD;
`ifdef LOADER_CHECKSUM_EN
                    sum_nx       = '0;
`endif
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else if (bus.in_valid) begin
                    we_nx        = 1'b1;
                    wa_nx        = addr;
                    wd_nx        = bus.in_data;
                    addr_nx      = (addr == last_addr) ? '0 : addr + 1'b1;
                    remaining_nx = remaining - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_nx       = sum_q + bus.in_data;
`endif
                    if (remaining == cnt_w'(1)) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == LOAD);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            we_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            remaining <= remaining_nx;
            we_q      <= we_nx;
            wa_q      <= wa_nx;
            wd_q      <= wd_nx;
            busy_q    <= busy_nx;
            done_q    <= done_nx;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_nx;
    end
`endif
endmodule

// File: tb/tb_memory_write_loader.sv
// Directed bench for memory_write_loader; checksum steps run when LOADER_CHECKSUM_EN is defined.
module tb_memory_write_loader;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    memory_write_loader_if #(.word_size(9)) lb ();

    memory_write_loader #(.word_size(9), .memory_size(512)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] e_we, input logic [31:0] e_wa,
                          input logic [31:0] e_wd);
        chk({tag, ".we"}, 32'(lb.we), e_we);
        if (e_we != 0) begin
            chk({tag, ".wa"}, 32'(lb.wa), e_wa);
            chk({tag, ".wd"}, 32'(lb.wd), e_wd);
        end
    endtask

    task automatic start_burst(input logic [8:0] base, input logic [9:0] cnt);
        lb.start     = 1'b1;
        lb.base_addr = base;
        lb.count     = cnt;
        tick();
        lb.start     = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        lb.start     = 1'b0;
        lb.base_addr = '0;
        lb.count     = '0;
        lb.abort     = 1'b0;
        lb.in_valid  = 1'b0;
        lb.in_data   = '0;
        repeat (2) tick();
        chk("rst.we", 32'(lb.we), 0);
        chk("rst.wa", 32'(lb.wa), 0);
        chk("rst.wd", 32'(lb.wd), 0);
        chk("rst.busy", 32'(lb.busy), 0);
        chk("rst.done", 32'(lb.done), 0);
        chk("rst.in_ready", 32'(lb.in_ready), 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a 5-word burst
        start_burst(9'd20, 10'd5);
        lb.in_valid = 1'b1; lb.in_data = 9'h0A1;
        tick();
        lb.in_data = 9'h0A2;
        tick();
        chk_wr("mrst.w2", 1, 21, 9'h0A2);
        lb.in_data = 9'h0A3;
        #2 rst = 1'b1;
        #1;
        chk("mrst.we", 32'(lb.we), 0);
        chk("mrst.busy", 32'(lb.busy), 0);
        chk("mrst.in_ready", 32'(lb.in_ready), 0);
        lb.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("mrst.idle_we", 32'(lb.we), 0);

        // Back-to-back burst base=10 count=3
        start_burst(9'd10, 10'd3);
        chk("b2b.busy", 32'(lb.busy), 1);
        chk("b2b.in_ready", 32'(lb.in_ready), 1);
        lb.in_valid = 1'b1; lb.in_data = 9'h011;
        tick();
        chk_wr("b2b.w0", 1, 10, 9'h011);
        chk("b2b.done0", 32'(lb.done), 0);
        lb.in_data = 9'h022;
        tick();
        chk_wr("b2b.w1", 1, 11, 9'h022);
        lb.in_data = 9'h033;
        tick();
        chk_wr("b2b.w2", 1, 12, 9'h033);
        chk("b2b.done", 32'(lb.done), 1);
        chk("b2b.busy_off", 32'(lb.busy), 0);
        chk("b2b.rdy_off", 32'(lb.in_ready), 0);
        lb.in_valid = 1'b0;
        tick();
        chk("b2b.done_end", 32'(lb.done), 0);
        chk("b2b.we_end", 32'(lb.we), 0);

        // Wrap-around with gaps: base=510 count=4
        start_burst(9'd510, 10'd4);
        lb.in_valid = 1'b1; lb.in_data = 9'd1;
        tick();
        chk_wr("wrap.w0", 1, 510, 1);
        lb.in_valid = 1'b0;
        tick();
        chk_wr("wrap.gap0", 0, 0, 0);
        lb.in_valid = 1'b1; lb.in_data = 9'd2;
        tick();
        chk_wr("wrap.w1", 1, 511, 2);
        lb.in_data = 9'd3;
        tick();
        chk_wr("wrap.w2", 1, 0, 3);
        lb.in_valid = 1'b0;
        tick();
        chk_wr("wrap.gap1", 0, 0, 0);
        chk("wrap.done_early", 32'(lb.done), 0);
        lb.in_valid = 1'b1; lb.in_data = 9'd4;
        tick();
        chk_wr("wrap.w3", 1, 1, 4);
        chk("wrap.done", 32'(lb.done), 1);
        lb.in_valid = 1'b0;
        tick();
        chk("wrap.done_end", 32'(lb.done), 0);

        // count=0: straight to DONE
        start_burst(9'd5, 10'd0);
        chk("zero.done", 32'(lb.done), 1);
        chk("zero.busy", 32'(lb.busy), 0);
        chk("zero.we", 32'(lb.we), 0);
        tick();
        chk("zero.done_end", 32'(lb.done), 0);
        chk("zero.busy_end", 32'(lb.busy), 0);

        // Abort after 2 writes of 5
        start_burst(9'd100, 10'd5);
        lb.in_valid = 1'b1; lb.in_data = 9'h0B1;
        tick();
        chk_wr("abt.w0", 1, 100, 9'h0B1);
        lb.in_data = 9'h0B2;
        tick();
        chk_wr("abt.w1", 1, 101, 9'h0B2);
        lb.abort = 1'b1; lb.in_data = 9'h0B3;
        #1;
        chk("abt.in_ready", 32'(lb.in_ready), 0);
        tick();
        chk("abt.we", 32'(lb.we), 0);
        chk("abt.busy", 32'(lb.busy), 0);
        chk("abt.done", 32'(lb.done), 0);
        lb.abort = 1'b0;
        #1;
        chk("abt.idle_rdy", 32'(lb.in_ready), 0);
        tick();
        chk("abt.we2", 32'(lb.we), 0);
        chk("abt.done2", 32'(lb.done), 0);
        lb.in_valid = 1'b0;
        start_burst(9'd200, 10'd1);
        lb.in_valid = 1'b1; lb.in_data = 9'h055;
        tick();
        chk_wr("abt.new", 1, 200, 9'h055);
        chk("abt.new_done", 32'(lb.done), 1);
        lb.in_valid = 1'b0;
        tick();

        // Oversized count saturates to 512 words
        start_burst(9'd0, 10'd700);
        lb.in_valid = 1'b1;
        for (int i = 0; i < 511; i++) begin
            lb.in_data = 9'(i);
            tick();
        end
        chk("sat.done_early", 32'(lb.done), 0);
        chk("sat.busy", 32'(lb.busy), 1);
        lb.in_data = 9'h1FF;
        tick();
        chk_wr("sat.last", 1, 511, 9'h1FF);
        chk("sat.done", 32'(lb.done), 1);
        lb.in_valid = 1'b0;
        tick();
        chk("sat.we_end", 32'(lb.we), 0);

`ifdef LOADER_CHECKSUM_EN
        start_burst(9'd40, 10'd2);
        chk("cks.clear", 32'(lb.checksum), 0);
        lb.in_valid = 1'b1; lb.in_data = 9'h1FF;
        tick();
        lb.in_data = 9'h002;
        tick();
        chk("cks.done", 32'(lb.done), 1);
        chk("cks.sum", 32'(lb.checksum), 9'h001);
        lb.in_valid = 1'b0;
        tick();
        chk("cks.hold", 32'(lb.checksum), 9'h001);
        start_burst(9'd0, 10'd0);
        chk("cks.restart", 32'(lb.checksum), 0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
